// File: rtl/apu_frame_counter.sv
// APU frame sequencer: divides CPU cycles into quarter/half-frame strobes, owns the $4017
// mode/IRQ-inhibit register, the deferred sequence reset and the frame IRQ flag.
module apu_frame_counter #(
  parameter logic [15:0] S1 = 16'd7457,
  parameter logic [15:0] S2 = 16'd14913,
  parameter logic [15:0] S3 = 16'd22371,
  parameter logic [15:0] S4 = 16'd29829,
  parameter logic [15:0] S5 = 16'd37281
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       wr,
  input  logic [7:0] wr_data,
  input  logic       status_rd,
  output logic       quarterframe,
  output logic       halfframe,
  output logic       irq,
  output logic       mode
);

  localparam logic [15:0] S4M1 = S4 - 16'd1;
  localparam logic [15:0] S4P1 = S4 + 16'd1;
  localparam logic [15:0] S5P1 = S5 + 16'd1;

  logic [15:0] cnt_q, cnt_d;
  logic        mode_q, mode_d;
  logic        inhibit_q, inhibit_d;
  logic        irq_q, irq_d;
  logic        parity_q, parity_d;
  logic        pend_q, pend_d;
  logic        pend_mode_q, pend_mode_d;
  logic [2:0]  pend_cnt_q, pend_cnt_d;
  logic        qf_q, qf_d;
  logic        hf_q, hf_d;

  logic [15:0] last;
  logic        apply;
  logic        inhibit_eff;
  logic        irq_set;
  logic        irq_clr;
  logic        q_dec;
  logic        h_dec;

  // Only the mode and inhibit bits of $4017 are meaningful here.
  logic unused_wr_bits;
  assign unused_wr_bits = ^wr_data[5:0];

  always_comb begin
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    inhibit_d   = inhibit_q;
    irq_d       = irq_q;
    parity_d    = parity_q;
    pend_d      = pend_q;
    pend_mode_d = pend_mode_q;
    pend_cnt_d  = pend_cnt_q;
    qf_d        = 1'b0;
    hf_d        = 1'b0;

    last        = mode_q ? S5P1 : S4P1;
    // A fresh write restarts the delay, so it can never coincide with the reset being applied.
    apply       = ce && !wr && pend_q && (pend_cnt_q == 3'd1);
    inhibit_eff = wr ? wr_data[6] : inhibit_q;
    irq_set     = !mode_q && !inhibit_eff &&
                  ((cnt_q == S4M1) || (cnt_q == S4) || (cnt_q == S4P1));
    irq_clr     = status_rd || (wr && wr_data[6]);

    if (mode_q) begin
      q_dec = (cnt_q == S1) || (cnt_q == S2) || (cnt_q == S3) || (cnt_q == S5);
      h_dec = (cnt_q == S2) || (cnt_q == S5);
    end else begin
      q_dec = (cnt_q == S1) || (cnt_q == S2) || (cnt_q == S3) || (cnt_q == S4);
      h_dec = (cnt_q == S2) || (cnt_q == S4);
    end

    if (ce) begin
      parity_d = ~parity_q;
      cnt_d    = (cnt_q == last) ? 16'd0 : cnt_q + 16'd1;

      if (irq_set) begin
        irq_d = 1'b1;
      end else if (irq_clr) begin
        irq_d = 1'b0;
      end

      if (wr) begin
        inhibit_d   = wr_data[6];
        pend_d      = 1'b1;
        pend_mode_d = wr_data[7];
        pend_cnt_d  = parity_q ? 3'd4 : 3'd3;
      end else if (pend_q) begin
        pend_cnt_d = pend_cnt_q - 3'd1;
      end

      if (apply) begin
        cnt_d  = 16'd0;
        mode_d = pend_mode_q;
        pend_d = 1'b0;
        qf_d   = pend_mode_q;
        hf_d   = pend_mode_q;
      end else begin
        qf_d = q_dec;
        hf_d = h_dec;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= 16'd0;
      mode_q      <= 1'b0;
      inhibit_q   <= 1'b0;
      irq_q       <= 1'b0;
      parity_q    <= 1'b0;
      pend_q      <= 1'b0;
      pend_mode_q <= 1'b0;
      pend_cnt_q  <= 3'd0;
      qf_q        <= 1'b0;
      hf_q        <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      inhibit_q   <= inhibit_d;
      irq_q       <= irq_d;
      parity_q    <= parity_d;
      pend_q      <= pend_d;
      pend_mode_q <= pend_mode_d;
      pend_cnt_q  <= pend_cnt_d;
      qf_q        <= qf_d;
      hf_q        <= hf_d;
    end
  end

  assign quarterframe = qf_q;
  assign halfframe    = hf_q;
  assign irq          = irq_q;
  assign mode         = mode_q;

endmodule

// File: tb/tb_apu_frame_counter.sv
// Scoreboard bench for apu_frame_counter: a cycle model pushes expected outputs per clock,
// directed checks cover reset, IRQ, deferred writes and async reset. Steps are shortened.
module tb_apu_frame_counter;

  localparam int P1 = 97;
  localparam int P2 = 193;
  localparam int P3 = 291;
  localparam int P4 = 387;
  localparam int P5 = 483;
  localparam int LIMIT = 4000;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic       wr;
  logic [7:0] wr_data;
  logic       status_rd;
  logic       quarterframe;
  logic       halfframe;
  logic       irq;
  logic       mode;

  apu_frame_counter #(
    .S1(16'(P1)),
    .S2(16'(P2)),
    .S3(16'(P3)),
    .S4(16'(P4)),
    .S5(16'(P5))
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .wr          (wr),
    .wr_data     (wr_data),
    .status_rd   (status_rd),
    .quarterframe(quarterframe),
    .halfframe   (halfframe),
    .irq         (irq),
    .mode        (mode)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [3:0] sb_q[$];

  int m_cnt;
  int m_left;
  bit m_mode, m_inh, m_irq, m_par, m_pend, m_pmode;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_left = 0;
    m_mode = 0; m_inh = 0; m_irq = 0; m_par = 0; m_pend = 0; m_pmode = 0;
  endtask

  task automatic model_step(input bit c, input bit w, input logic [7:0] d, input bit r);
    bit q, h, apply, set, inh;
    int last;
    q = 0; h = 0;
    if (c) begin
      last  = m_mode ? P5 + 1 : P4 + 1;
      apply = !w && m_pend && (m_left == 1);
      inh   = w ? d[6] : m_inh;
      set   = !m_mode && !inh && (m_cnt >= P4 - 1) && (m_cnt <= P4 + 1);
      if (apply) begin
        q = m_pmode; h = m_pmode;
      end else if (m_mode) begin
        q = (m_cnt == P1) || (m_cnt == P2) || (m_cnt == P3) || (m_cnt == P5);
        h = (m_cnt == P2) || (m_cnt == P5);
      end else begin
        q = (m_cnt == P1) || (m_cnt == P2) || (m_cnt == P3) || (m_cnt == P4);
        h = (m_cnt == P2) || (m_cnt == P4);
      end
      if (set) m_irq = 1;
      else if (r || (w && d[6])) m_irq = 0;
      m_cnt = apply ? 0 : ((m_cnt == last) ? 0 : m_cnt + 1);
      if (w) begin
        m_inh = d[6]; m_pend = 1; m_pmode = d[7]; m_left = m_par ? 4 : 3;
      end else if (m_pend) begin
        m_left--;
        if (m_left == 0) begin
          m_pend = 0;
          m_mode = m_pmode;
        end
      end
      m_par = ~m_par;
    end
    sb_q.push_back({q, h, m_irq, m_mode});
  endtask

  task automatic tick(input bit c, input bit w, input logic [7:0] d, input bit r);
    logic [3:0] exp;
    ce = c; wr = w; wr_data = d; status_rd = r;
    model_step(c, w, d, r);
    @(posedge clk);
    #1;
    exp = sb_q.pop_front();
    check_eq("sb", 32'({quarterframe, halfframe, irq, mode}), 32'(exp));
    ce = 0; wr = 0; wr_data = 8'h00; status_rd = 0;
  endtask

  // Advance until the next ce would sample cnt == target.
  task automatic run_to(input int target);
    int guard = 0;
    while (m_cnt != target && guard < LIMIT) begin
      tick(1, 0, 8'h00, 0);
      guard++;
    end
    if (guard == LIMIT) check_eq("run_to_timeout", 32'(m_cnt), 32'(target));
  endtask

  task automatic to_strobe(output int n);
    n = 0;
    do begin
      tick(1, 0, 8'h00, 0);
      n++;
    end while (!(quarterframe || halfframe) && n < LIMIT);
    if (n >= LIMIT) check_eq("strobe_timeout", 32'(quarterframe | halfframe), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    rst = 0; ce = 0; wr = 0; wr_data = 8'h00; status_rd = 0;
    model_reset();
    #12;
    check_eq("reset_outs", 32'({quarterframe, halfframe, irq, mode}), 32'd0);
    @(negedge clk);
    rst = 1;

    // 4-step free run and frame IRQ
    to_strobe(n);
    check_eq("q1_delay", 32'(n), 32'(P1 + 1));
    check_eq("q1_half", 32'(halfframe), 32'd0);
    to_strobe(n);
    check_eq("q2_delay", 32'(n), 32'(P2 - P1));
    check_eq("q2_half", 32'(halfframe), 32'd1);
    to_strobe(n);
    check_eq("q3_delay", 32'(n), 32'(P3 - P2));
    run_to(P4 - 1);
    check_eq("irq_pre", 32'(irq), 32'd0);
    tick(1, 0, 8'h00, 0);
    check_eq("irq_rise", 32'(irq), 32'd1);
    tick(1, 0, 8'h00, 0);
    check_eq("q4_both", 32'({quarterframe, halfframe}), 32'd3);
    tick(1, 0, 8'h00, 1);
    check_eq("irq_set_wins", 32'(irq), 32'd1);
    run_to(10);
    tick(1, 0, 8'h00, 1);
    check_eq("irq_read_clear", 32'(irq), 32'd0);
    to_strobe(n);
    check_eq("period_wrap", 32'(n), 32'(P1 - 10));

    // Async reset mid-run with irq set
    run_to(P4 + 1);
    run_to(260);
    check_eq("pre_rst_irq", 32'(irq), 32'd1);
    #2;
    rst = 0;
    #1;
    check_eq("async_rst", 32'({quarterframe, halfframe, irq, mode}), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1;
    to_strobe(n);
    check_eq("rst_first_qf", 32'(n), 32'(P1 + 1));

    // Odd-parity write setting inhibit
    run_to(P4 + 1);
    run_to(5);
    if (!m_par) tick(1, 0, 8'h00, 0);
    check_eq("pre_wr_irq", 32'(irq), 32'd1);
    tick(1, 1, 8'h40, 0);
    check_eq("wr40_clear", 32'(irq), 32'd0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1, 0, 8'h00, 0);
      seen |= quarterframe | halfframe;
    end
    check_eq("odd_no_strobe", 32'(seen), 32'd0);
    to_strobe(n);
    check_eq("odd_realign", 32'(n), 32'(P1 + 1));
    run_to(P4 + 1);
    tick(1, 0, 8'h00, 0);
    check_eq("inhibit_holds", 32'(irq), 32'd0);

    // 5-step write on even parity
    run_to(20);
    if (m_par) tick(1, 0, 8'h00, 0);
    tick(1, 1, 8'h80, 0);
    check_eq("mode_on_write", 32'(mode), 32'd0);
    tick(1, 0, 8'h00, 0);
    tick(1, 0, 8'h00, 0);
    check_eq("mode_held", 32'({quarterframe, halfframe, mode}), 32'd0);
    tick(1, 0, 8'h00, 0);
    check_eq("w80_apply", 32'({quarterframe, halfframe, mode}), 32'd7);
    to_strobe(n);
    check_eq("5s_q1", 32'(n), 32'(P1 + 1));
    to_strobe(n);
    check_eq("5s_h1", 32'({n, halfframe}), 32'({P2 - P1, 1'b1}));
    to_strobe(n);
    check_eq("5s_q3", 32'({n, halfframe}), 32'({P3 - P2, 1'b0}));
    to_strobe(n);
    check_eq("5s_h2", 32'({n, halfframe}), 32'({P5 - P3, 1'b1}));
    to_strobe(n);
    check_eq("5s_period", 32'(n), 32'(P1 + 2));
    seen = 0;
    for (int i = 0; i < 3 * (P5 + 2); i++) begin
      tick(1, 0, 8'h00, 0);
      seen |= irq;
    end
    check_eq("5s_no_irq", 32'(seen), 32'd0);

    // Back-to-back writes: only the second takes effect
    run_to(30);
    tick(1, 1, 8'h80, 0);
    tick(1, 0, 8'h00, 0);
    tick(1, 1, 8'h00, 0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1, 0, 8'h00, 0);
      seen |= quarterframe | halfframe;
    end
    check_eq("b2b_no_strobe", 32'(seen), 32'd0);
    check_eq("b2b_mode", 32'(mode), 32'd0);

    // Sparse ce, including writes and reads without ce
    for (int i = 0; i < 3 * (P4 + 2); i++) begin
      if (i == 50) tick(0, 1, 8'hc0, 0);
      else if (i == 400) tick(0, 0, 8'h00, 1);
      else tick(1'($urandom_range(0, 1)), 0, 8'h00, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
